// File: rtl/pll_div_pkg.sv
// Shared types, defaults and the configuration clamp for the divider clock generator.
package pll_div_pkg;

  // Default channel counter width; the cfg_t fields below are this wide.
  localparam int CNT_W_DFLT    = 8;
  // Reset divide and high-time loaded into every channel.
  localparam int DEF_DIV_DFLT  = 16;
  localparam int DEF_HIGH_DFLT = 8;
  // Stable cycles required after the last config event before locked rises.
  localparam int LOCK_CNT_DFLT = 16;
  // Width of the lock counter.
  localparam int LOCK_W        = 16;

  typedef logic [CNT_W_DFLT-1:0] cnt_t;

  // One channel's programmable timing.
  typedef struct packed {
    cnt_t div;    // period in inclk0 cycles
    cnt_t high;   // cycles the output is high within a period
    cnt_t phase;  // counter value loaded on resync
  } cfg_t;

  // Force a requested configuration into the legal range. The divide is fixed
  // first so that high and phase are limited against the value actually used.
  function automatic cfg_t cfg_clamp(input cfg_t req);
    cfg_t r;
    r = req;
    if (r.div < cnt_t'(2)) r.div = cnt_t'(2);
    if (r.high == '0) r.high = cnt_t'(1);
    if (r.high >= r.div) r.high = r.div - cnt_t'(1);
    if (r.phase >= r.div) r.phase = r.div - cnt_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/pll_div_gen_if.sv
// Configuration write port of the divider clock generator.
//
// Handshake: a write transfers on a rising inclk0 edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_ch/cfg_div/cfg_high/cfg_phase
// stable while cfg_valid is high and may not withdraw cfg_valid before the
// transfer. cfg_ready is low while any channel holds an unapplied update, so at
// most one update is outstanding. A write to a channel number >= NUM_CH is
// accepted and discarded.
interface pll_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = pll_div_pkg::CNT_W_DFLT
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/pll_div_chan.sv
// One output channel: free-running period counter, active and shadow timing
// registers, wrap-aligned update and registered clock output.
module pll_div_chan
  import pll_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DFLT,
  parameter int DEF_DIV  = DEF_DIV_DFLT,
  parameter int DEF_HIGH = DEF_HIGH_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,     // accepted write targets this channel
  input  logic [CNT_W-1:0] wr_div,    // already clamped
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  input  logic             resync,
  output logic             clk_out,
  output logic             pending,   // shadow holds an unapplied update
  output logic             apply      // shadow moves to active on this edge
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_a, high_a, phase_a;
  logic [CNT_W-1:0] div_s, high_s, phase_s;
  logic             wrap;

  // Last count of the current period; the next period starts at zero.
  assign wrap  = (cnt == div_a - 1'b1);

  // A pending update lands on a period boundary or on resync, never mid-period,
  // so the output never produces a shortened pulse.
  assign apply = pending & (wrap | resync);

  // Counter, timing registers and output flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_a   <= CNT_W'(DEF_DIV);
      high_a  <= CNT_W'(DEF_HIGH);
      phase_a <= '0;
      div_s   <= CNT_W'(DEF_DIV);
      high_s  <= CNT_W'(DEF_HIGH);
      phase_s <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      // Output reflects the period position before this edge.
      clk_out <= (cnt < high_a);

      // Resync jumps to the phase of whichever timing is active afterwards.
      if (resync) begin
        cnt <= apply ? phase_s : phase_a;
      end else if (wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (apply) begin
        div_a   <= div_s;
        high_a  <= high_s;
        phase_a <= phase_s;
        pending <= 1'b0;
      end

      // A write arrives only while nothing is pending, so it never races apply.
      if (wr_en) begin
        div_s   <= wr_div;
        high_s  <= wr_high;
        phase_s <= wr_phase;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_div_gen.sv
// Multi-channel divider clock generator: config handshake and channel decode,
// resync fan-out to all channels, and the lock indicator.
// areset_n asserts asynchronously; its release is expected to be already
// synchronous to inclk0 (supplied by the upstream reset bridge).
module pll_div_gen
  import pll_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DFLT,    // must not exceed CNT_W_DFLT
  parameter int LOCK_CNT = LOCK_CNT_DFLT,
  parameter int DEF_DIV  = DEF_DIV_DFLT,
  parameter int DEF_HIGH = DEF_HIGH_DFLT
) (
  input  logic              inclk0,
  input  logic              areset_n,
  pll_div_gen_if.slave      cfg,
  input  logic              resync,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              accept;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] apply;
  cfg_t              raw_cfg;
  cfg_t              clamp_cfg;
  logic [LOCK_W-1:0] lock_cnt;

  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg.cfg_ready = ~|pending;

  // Clamp once at the port so every channel stores only legal timing.
  assign raw_cfg   = '{div: cnt_t'(cfg.cfg_div), high: cnt_t'(cfg.cfg_high),
                       phase: cnt_t'(cfg.cfg_phase)};
  assign clamp_cfg = cfg_clamp(raw_cfg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Out-of-range channel numbers match no channel and are dropped here.
      assign wr_en[gi] = accept & (cfg.cfg_ch == CH_W'(gi));

      pll_div_chan #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (DEF_DIV),
        .DEF_HIGH (DEF_HIGH)
      ) u_chan (
        .clk      (inclk0),
        .rst_n    (areset_n),
        .wr_en    (wr_en[gi]),
        .wr_div   (clamp_cfg.div[CNT_W-1:0]),
        .wr_high  (clamp_cfg.high[CNT_W-1:0]),
        .wr_phase (clamp_cfg.phase[CNT_W-1:0]),
        .resync   (resync),
        .clk_out  (clk_out[gi]),
        .pending  (pending[gi]),
        .apply    (apply[gi])
      );
    end
  endgenerate

  // Lock counter: restarts on any config event (including discarded writes),
  // otherwise counts up and saturates at LOCK_CNT.
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      lock_cnt <= '0;
    end else if (accept | (|apply) | resync) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_W'(LOCK_CNT)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign locked = (lock_cnt == LOCK_W'(LOCK_CNT));

endmodule

// File: tb/tb_pll_div_gen.sv
// Directed bench for pll_div_gen: defaults, reprogramming with clamping,
// wrap-aligned apply, resync phasing, resync racing a write, and mid-update reset.
module tb_pll_div_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              inclk0 = 1'b0;
  logic              areset_n;
  logic              resync;
  logic [NUM_CH-1:0] clk_out;
  logic              locked;

  int n_cmp = 0;
  int n_mis = 0;

  pll_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  pll_div_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .LOCK_CNT (16),
    .DEF_DIV  (16),
    .DEF_HIGH (8)
  ) dut (
    .inclk0   (inclk0),
    .areset_n (areset_n),
    .cfg      (cfg_if),
    .resync   (resync),
    .clk_out  (clk_out),
    .locked   (locked)
  );

  // Clock and watchdog.
  always #5 inclk0 = ~inclk0;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle config write, optionally with resync on the same edge.
  task automatic cfg_write(input int ch, input int div, input int high,
                           input int phase, input logic rs);
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = CNT_W'(div);
    cfg_if.cfg_high  = CNT_W'(high);
    cfg_if.cfg_phase = CNT_W'(phase);
    cfg_if.cfg_valid = 1'b1;
    resync           = rs;
    tick();
    cfg_if.cfg_valid = 1'b0;
    resync           = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (cfg_if.cfg_ready !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  // Measure one full period and its high time on a channel, starting at a rise.
  task automatic measure(input int ch, output int period, output int high);
    int n;
    n = 0; period = 0; high = 0;
    while (clk_out[ch] !== 1'b0 && n < 100) begin tick(); n++; end
    while (clk_out[ch] !== 1'b1 && n < 100) begin tick(); n++; end
    while (clk_out[ch] === 1'b1 && n < 100) begin tick(); n++; high++; end
    period = high;
    while (clk_out[ch] === 1'b0 && n < 100) begin tick(); n++; period++; end
    if (n >= 100) begin
      period = 0;
      high   = 0;
    end
  endtask

  initial begin
    int w, p, h;
    logic [9:0]  pat10;
    logic [3:0]  pat4;
    logic [7:0]  pat_a, pat_b;
    logic [13:0] pat_c, pat_r;

    areset_n         = 1'b0;
    resync           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    cfg_if.cfg_phase = '0;

    // Reset state.
    repeat (3) tick();
    chk("rst_clk_out", clk_out, 4'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ready", cfg_if.cfg_ready, 1'b1);

    // Release: all outputs rise after one cycle; locked after 16.
    areset_n = 1'b1;
    tick();
    chk("first_rise", clk_out, 4'hF);
    repeat (14) tick();
    chk("lock_at_15", locked, 1'b0);
    tick();
    chk("lock_at_16", locked, 1'b1);
    measure(0, p, h);
    chk("def_period_ch0", p, 16);
    chk("def_high_ch0", h, 8);
    measure(3, p, h);
    chk("def_period_ch3", p, 16);
    chk("def_high_ch3", h, 8);
    chk("def_locked_hold", locked, 1'b1);

    // ch1 -> div 5 high 2: ready held low until the ch1 wrap.
    cfg_write(1, 5, 2, 0, 1'b0);
    chk("w1_ready_drop", cfg_if.cfg_ready, 1'b0);
    chk("w1_lock_drop", locked, 1'b0);
    wait_ready(20, w);
    chk("w1_ready_back", cfg_if.cfg_ready, 1'b1);
    chk("w1_latency_le16", (w <= 16), 1'b1);
    pat10 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat10 = {pat10[8:0], clk_out[1]};
    end
    chk("w1_no_runt_pattern", pat10, 10'b1100011000);
    measure(1, p, h);
    chk("w1_period_ch1", p, 5);
    chk("w1_high_ch1", h, 2);
    measure(0, p, h);
    chk("w1_period_ch0", p, 16);
    chk("w1_high_ch0", h, 8);

    // ch2 -> div 1 high 0 clamps to div 2 high 1.
    cfg_write(2, 1, 0, 0, 1'b0);
    wait_ready(20, w);
    chk("w2_ready_back", cfg_if.cfg_ready, 1'b1);
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat4 = {pat4[2:0], clk_out[2]};
    end
    chk("w2_toggle_pattern", pat4, 4'b1010);
    measure(2, p, h);
    chk("w2_period_ch2", p, 2);
    chk("w2_high_ch2", h, 1);

    // ch2 -> div 10 high 12 clamps high to 9.
    cfg_write(2, 10, 12, 0, 1'b0);
    wait_ready(5, w);
    chk("w3_ready_back", cfg_if.cfg_ready, 1'b1);
    measure(2, p, h);
    chk("w3_period_ch2", p, 10);
    chk("w3_high_ch2", h, 9);

    // ch0 and ch3 at div 8 high 4, phases 0 and 4, then resync.
    cfg_write(0, 8, 4, 0, 1'b0);
    wait_ready(20, w);
    chk("w4_ready_back", cfg_if.cfg_ready, 1'b1);
    cfg_write(3, 8, 4, 4, 1'b0);
    wait_ready(20, w);
    chk("w5_ready_back", cfg_if.cfg_ready, 1'b1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("rs_lock_drop", locked, 1'b0);
    pat_a = '0;
    pat_b = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat_a = {pat_a[6:0], clk_out[0]};
      pat_b = {pat_b[6:0], clk_out[3]};
    end
    chk("rs_ch0_pattern", pat_a, 8'b11110000);
    chk("rs_ch3_pattern", pat_b, 8'b00001111);
    repeat (7) tick();
    chk("rs_lock_at_15", locked, 1'b0);
    tick();
    chk("rs_lock_at_16", locked, 1'b1);

    // Resync on the accept edge of a ch0 write: old div 8 first, then div 6 high 3.
    cfg_write(0, 6, 3, 0, 1'b1);
    chk("sim_ready_drop", cfg_if.cfg_ready, 1'b0);
    pat_c = '0;
    pat_r = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      pat_c = {pat_c[12:0], clk_out[0]};
      pat_r = {pat_r[12:0], cfg_if.cfg_ready};
    end
    chk("sim_ch0_pattern", pat_c, 14'b11110000111000);
    chk("sim_ready_pattern", pat_r, 14'b00000001111111);

    // Reset while an update is pending.
    cfg_write(1, 20, 5, 0, 1'b0);
    chk("mid_ready_drop", cfg_if.cfg_ready, 1'b0);
    areset_n = 1'b0;
    #1;
    chk("mid_rst_clk_out", clk_out, 4'h0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_ready", cfg_if.cfg_ready, 1'b1);
    repeat (2) tick();
    areset_n = 1'b1;
    tick();
    chk("mid_first_rise", clk_out, 4'hF);
    measure(1, p, h);
    chk("mid_period_ch1", p, 16);
    chk("mid_high_ch1", h, 8);
    measure(2, p, h);
    chk("mid_period_ch2", p, 16);
    chk("mid_high_ch2", h, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
